// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA raster controller:
//   - default 640x480@60 Hz timing constants (pixel clock = clk / CLK_DIV)
//   - derived totals and sync windows for the default timing
//   - bit-field positions of the 16-bit frame-buffer pixel word
//   - counter width, test-pattern bar width and the bar colour helper
// -----------------------------------------------------------------------------
package vga_pkg;

  // Default timing (pixels / lines)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_ADDR_W   = 19;

  // Derived values for the default timing; sync windows are inclusive
  localparam int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int HS_END   = HS_START + DEF_H_SYNC - 1;
  localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int VS_END   = VS_START + DEF_V_SYNC - 1;

  // Pixel word layout: [15:12] unused, [11:8] R, [7:4] G, [3:0] B
  localparam int PIX_R_MSB = 11;
  localparam int PIX_R_LSB = 8;
  localparam int PIX_G_MSB = 7;
  localparam int PIX_G_LSB = 4;
  localparam int PIX_B_MSB = 3;
  localparam int PIX_B_LSB = 0;

  // Width of h_cnt / v_cnt; wide enough for any sensible VGA timing
  localparam int CNT_W = 12;

  // Test pattern: 8 vertical bars of this many pixels
  localparam int BAR_W = 80;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Bar index bits {2,1,0} drive R, G, B fully on or fully off
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    c.r = {4{idx[2]}};
    c.g = {4{idx[1]}};
    c.b = {4{idx[0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_scan_counter.sv
// -----------------------------------------------------------------------------
// vga_scan_counter
// Stage 0 of the raster pipeline: clock divider, h/v position counters,
// active/sync decode and the incrementing frame-buffer address.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   en_i            scan enable; low clears and holds all counters at 0
//   h_cnt_o         current horizontal position (used by the test pattern)
//   active_o        current position is inside the visible area
//   hs_n_o, vs_n_o  decoded syncs for the current position, active-low
//   load_o          output-register load strobe (div == 1)
//   frame_start_o   combinational pulse on the pixel tick at (0,0)
//   pixel_addr_o    frame-buffer read address
// -----------------------------------------------------------------------------
module vga_scan_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  output logic [CNT_W-1:0]  h_cnt_o,
  output logic              active_o,
  output logic              hs_n_o,
  output logic              vs_n_o,
  output logic              load_o,
  output logic              frame_start_o,
  output logic [ADDR_W-1:0] pixel_addr_o
);

  localparam int LINE_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_FIRST    = H_ACTIVE + H_FP;
  localparam int HS_LAST     = HS_FIRST + H_SYNC - 1;
  localparam int VS_FIRST    = V_ACTIVE + V_FP;
  localparam int VS_LAST     = VS_FIRST + V_SYNC - 1;
  localparam int DIV_W       = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(LINE_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(FRAME_LINES - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_LO    = CNT_W'(HS_FIRST);
  localparam logic [CNT_W-1:0] HS_HI    = CNT_W'(HS_LAST);
  localparam logic [CNT_W-1:0] VS_LO    = CNT_W'(VS_FIRST);
  localparam logic [CNT_W-1:0] VS_HI    = CNT_W'(VS_LAST);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0]  v_cnt_q, v_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              tick;
  logic              h_wrap;
  logic              v_wrap;
  logic              active;

  always_comb begin
    tick    = en_i && (div_q == DIV_LAST);
    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = (v_cnt_q == V_LAST);
    active  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

    div_d   = div_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    addr_d  = addr_q;

    if (!en_i) begin
      // Disabled: park at (0,0) so that re-enabling starts a fresh frame
      div_d   = '0;
      h_cnt_d = '0;
      v_cnt_d = '0;
      addr_d  = '0;
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
        if (h_wrap) begin
          v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
        end
        // Address follows the raster: +1 when leaving a visible pixel,
        // cleared when wrapping into (0,0), held through blanking.
        if (h_wrap && v_wrap) begin
          addr_d = '0;
        end else if (active) begin
          addr_d = addr_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      addr_q  <= '0;
    end else begin
      div_q   <= div_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      addr_q  <= addr_d;
    end
  end

  assign h_cnt_o       = h_cnt_q;
  assign active_o      = active;
  assign hs_n_o        = !((h_cnt_q >= HS_LO) && (h_cnt_q <= HS_HI));
  assign vs_n_o        = !((v_cnt_q >= VS_LO) && (v_cnt_q <= VS_HI));
  // div==1 is one clk after the frame buffer has seen the new address,
  // so pixel_data is valid here; loading syncs on the same edge keeps
  // them aligned with RGB.
  assign load_o        = en_i && (div_q == DIV_LOAD);
  assign frame_start_o = tick && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign pixel_addr_o  = addr_q;

endmodule

// File: rtl/vga_scan_ctrl.sv
// -----------------------------------------------------------------------------
// vga_scan_ctrl
// VGA raster controller: 640x480@60 Hz timing from a 100 MHz clock, reads
// the frame buffer and drives syncs and 4:4:4 RGB.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   en                   scan enable (level); low blanks outputs, parks at (0,0)
//   test_mode            selects the built-in colour-bar generator
//   pixel_addr           frame-buffer read address
//   pixel_data           frame-buffer word, valid 1 clk after pixel_addr
//   h_sync, v_sync       syncs, active-low
//   Red, Green, Blue     colour outputs
//   frame_start          1-clk pulse on the pixel tick at (0,0)
// Build option:
//   VGA_TEST_PATTERN_EN  when defined, test_mode=1 replaces visible pixels with
//                        8 vertical bars of 80 px; otherwise test_mode is ignored
// -----------------------------------------------------------------------------
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              test_mode,
  output logic [ADDR_W-1:0] pixel_addr,
  input  logic [15:0]       pixel_data,
  output logic              h_sync,
  output logic              v_sync,
  output logic [3:0]        Red,
  output logic [3:0]        Green,
  output logic [3:0]        Blue,
  output logic              frame_start
);

  logic [CNT_W-1:0] h_cnt;
  logic             active;
  logic             hs_n;
  logic             vs_n;
  logic             load;
  rgb_t             fb_rgb;
  rgb_t             src_rgb;
  rgb_t             rgb_q, rgb_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             unused_pix;

  vga_scan_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CLK_DIV  (CLK_DIV),
    .ADDR_W   (ADDR_W)
  ) u_counter (
    .clk           (clk),
    .reset         (reset),
    .en_i          (en),
    .h_cnt_o       (h_cnt),
    .active_o      (active),
    .hs_n_o        (hs_n),
    .vs_n_o        (vs_n),
    .load_o        (load),
    .frame_start_o (frame_start),
    .pixel_addr_o  (pixel_addr)
  );

  always_comb begin
    fb_rgb.r = pixel_data[PIX_R_MSB:PIX_R_LSB];
    fb_rgb.g = pixel_data[PIX_G_MSB:PIX_G_LSB];
    fb_rgb.b = pixel_data[PIX_B_MSB:PIX_B_LSB];
  end

  assign unused_pix = ^pixel_data[15:12];

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0] bar_idx;
  logic       unused_bar;

  assign bar_idx    = h_cnt[9:0] / 10'(BAR_W);
  assign src_rgb    = test_mode ? bar_colour(bar_idx[2:0]) : fb_rgb;
  assign unused_bar = ^{bar_idx[9:3], h_cnt[CNT_W-1:10]};
`else
  logic unused_bar;

  assign src_rgb    = fb_rgb;
  assign unused_bar = ^{test_mode, h_cnt};
`endif

  // Output register: blanking is applied here so that sync and RGB share
  // the same two-clk latency from the counters.
  always_comb begin
    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    if (!en) begin
      rgb_d = '0;
      hs_d  = 1'b1;
      vs_d  = 1'b1;
    end else if (load) begin
      rgb_d = active ? src_rgb : '0;
      hs_d  = hs_n;
      vs_d  = vs_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign h_sync = hs_q;
  assign v_sync = vs_q;
  assign Red    = rgb_q.r;
  assign Green  = rgb_q.g;
  assign Blue   = rgb_q.b;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_scan_ctrl
// Directed bench: full horizontal timing, shortened vertical timing
// (4 visible lines, FP 1, sync 2, BP 1 -> 8 lines = 25600 clk per frame).
// Position k counts falling edges after the falling edge where frame_start
// is seen; the rising edge that entered (0,0) lies 3 clk before that, so a
// pin change 2 clk after entering pixel h first shows at k = 4*h - 1.
// -----------------------------------------------------------------------------
module tb_vga_scan_ctrl;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam int CLK_DIV  = 4;
  localparam int ADDR_W   = 19;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic              test_mode;
  logic [ADDR_W-1:0] pixel_addr;
  logic [15:0]       pixel_data;
  logic              h_sync;
  logic              v_sync;
  logic [3:0]        Red;
  logic [3:0]        Green;
  logic [3:0]        Blue;
  logic              frame_start;
  logic [11:0]       rgb;

  int checks   = 0;
  int failures = 0;

  assign rgb = {Red, Green, Blue};

  always #5 clk = ~clk;

  vga_scan_ctrl #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CLK_DIV  (CLK_DIV),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .test_mode   (test_mode),
    .pixel_addr  (pixel_addr),
    .pixel_data  (pixel_data),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .Red         (Red),
    .Green       (Green),
    .Blue        (Blue),
    .frame_start (frame_start)
  );

  // Step falling edges until frame_start is seen (bounded)
  task automatic wait_frame_start(input string name);
    int n;
    n = 0;
    while (frame_start !== 1'b1 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_start !== 1'b1) begin
      failures++;
      $display("FAIL %s_frame_start_timeout: got %b after %0d clk, required 1", name, frame_start, n);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    en         = 1'b1;
    test_mode  = 1'b0;
    pixel_data = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks += 5;
      if (h_sync !== 1'b1) begin failures++; $display("FAIL reset_h_sync: got %b required 1", h_sync); end
      if (v_sync !== 1'b1) begin failures++; $display("FAIL reset_v_sync: got %b required 1", v_sync); end
      if (rgb !== 12'h000) begin failures++; $display("FAIL reset_rgb: got %h required 000", rgb); end
      if (pixel_addr !== '0) begin failures++; $display("FAIL reset_addr: got %0d required 0", pixel_addr); end
      if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_frame_start: got %b required 0", frame_start); end
    end
    $display("test_reset done: checks=%0d failures=%0d", checks, failures);
  endtask

  // Ends on the falling edge where frame_start is high (k = 0)
  task automatic test_first_pixel();
    reset      = 1'b0;
    pixel_data = 16'h0ABC;
    @(negedge clk);
    checks += 3;
    if (rgb !== 12'h000) begin failures++; $display("FAIL first_rgb_j1: got %h required 000", rgb); end
    if (frame_start !== 1'b0) begin failures++; $display("FAIL first_fs_j1: got %b required 0", frame_start); end
    if (pixel_addr !== '0) begin failures++; $display("FAIL first_addr_j1: got %0d required 0", pixel_addr); end
    @(negedge clk);
    checks += 2;
    if (rgb !== 12'hABC) begin failures++; $display("FAIL first_rgb_j2: got %h required ABC", rgb); end
    if (frame_start !== 1'b0) begin failures++; $display("FAIL first_fs_j2: got %b required 0", frame_start); end
    @(negedge clk);
    checks += 2;
    if (frame_start !== 1'b1) begin failures++; $display("FAIL first_fs_j3: got %b required 1", frame_start); end
    if (pixel_addr !== '0) begin failures++; $display("FAIL first_addr_j3: got %0d required 0", pixel_addr); end
    $display("test_first_pixel done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_line();
    int hs_first;
    int hs_low;
    int rgb_first_zero;
    int rgb_lit;
    hs_first       = -1;
    hs_low         = 0;
    rgb_first_zero = -1;
    rgb_lit        = 0;
    wait_frame_start("line");
    for (int k = 1; k <= 3200; k++) begin
      @(negedge clk);
      if (h_sync === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = k;
      end
      if (k <= 3198) begin
        if (rgb === 12'hABC) rgb_lit++;
        if (rgb === 12'h000 && rgb_first_zero < 0) rgb_first_zero = k;
      end
      if (k == 401) begin
        checks++;
        if (pixel_addr !== 19'd101) begin failures++; $display("FAIL line_addr_h101: got %0d required 101", pixel_addr); end
      end
      if (k == 3199) begin
        checks++;
        if (rgb !== 12'hABC) begin failures++; $display("FAIL line1_first_rgb: got %h required ABC", rgb); end
      end
    end
    checks += 4;
    if (hs_first != 2623) begin failures++; $display("FAIL hsync_start: got k=%0d required k=2623", hs_first); end
    if (hs_low != 384) begin failures++; $display("FAIL hsync_width: got %0d clk required 384", hs_low); end
    if (rgb_first_zero != 2559) begin failures++; $display("FAIL rgb_blank_start: got k=%0d required k=2559", rgb_first_zero); end
    if (rgb_lit != 2558) begin failures++; $display("FAIL rgb_lit_count: got %0d required 2558", rgb_lit); end
    $display("test_line done: checks=%0d failures=%0d", checks, failures);
  endtask

  // Ends on the falling edge of the following frame_start
  task automatic test_frame();
    int vs_first;
    int vs_low;
    int fs_extra;
    vs_first = -1;
    vs_low   = 0;
    fs_extra = 0;
    wait_frame_start("frame");
    for (int k = 1; k <= 25600; k++) begin
      @(negedge clk);
      if (v_sync === 1'b0) begin
        vs_low++;
        if (vs_first < 0) vs_first = k;
      end
      if (k < 25600 && frame_start !== 1'b0) fs_extra++;
      if (k == 3217) begin
        checks++;
        if (pixel_addr !== 19'd645) begin failures++; $display("FAIL frame_addr_645: got %0d required 645", pixel_addr); end
      end
      if (k == 12153) begin
        checks++;
        if (pixel_addr !== 19'd2559) begin failures++; $display("FAIL frame_addr_last: got %0d required 2559", pixel_addr); end
      end
      if (k == 12157) begin
        checks++;
        if (pixel_addr !== 19'd2560) begin failures++; $display("FAIL frame_addr_blank: got %0d required 2560", pixel_addr); end
      end
      if (k == 25596) begin
        checks++;
        if (pixel_addr !== 19'd2560) begin failures++; $display("FAIL frame_addr_hold: got %0d required 2560", pixel_addr); end
      end
      if (k == 25600) begin
        checks += 2;
        if (frame_start !== 1'b1) begin failures++; $display("FAIL frame_start_period: got %b required 1", frame_start); end
        if (pixel_addr !== '0) begin failures++; $display("FAIL frame_addr_wrap: got %0d required 0", pixel_addr); end
      end
    end
    checks += 3;
    if (vs_first != 15999) begin failures++; $display("FAIL vsync_start: got k=%0d required k=15999", vs_first); end
    if (vs_low != 6400) begin failures++; $display("FAIL vsync_width: got %0d clk required 6400", vs_low); end
    if (fs_extra != 0) begin failures++; $display("FAIL frame_start_extra: got %0d pulses required 0", fs_extra); end
    $display("test_frame done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_en_drop();
    int bad;
    bad = 0;
    wait_frame_start("en_drop");
    for (int k = 1; k <= 1197; k++) @(negedge clk);
    checks += 2;
    if (rgb !== 12'hABC) begin failures++; $display("FAIL en_pre_rgb: got %h required ABC", rgb); end
    if (pixel_addr !== 19'd300) begin failures++; $display("FAIL en_pre_addr: got %0d required 300", pixel_addr); end
    en = 1'b0;
    @(negedge clk);
    checks += 5;
    if (h_sync !== 1'b1) begin failures++; $display("FAIL en_off_h_sync: got %b required 1", h_sync); end
    if (v_sync !== 1'b1) begin failures++; $display("FAIL en_off_v_sync: got %b required 1", v_sync); end
    if (rgb !== 12'h000) begin failures++; $display("FAIL en_off_rgb: got %h required 000", rgb); end
    if (pixel_addr !== '0) begin failures++; $display("FAIL en_off_addr: got %0d required 0", pixel_addr); end
    if (frame_start !== 1'b0) begin failures++; $display("FAIL en_off_fs: got %b required 0", frame_start); end
    for (int i = 0; i < 99; i++) begin
      @(negedge clk);
      if (h_sync !== 1'b1 || v_sync !== 1'b1 || rgb !== 12'h000 ||
          pixel_addr !== '0 || frame_start !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL en_off_hold: got %0d bad clk required 0", bad); end
    en = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      checks++;
      if (frame_start !== ((j == 3) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL en_restart_fs_j%0d: got %b required %b", j, frame_start, (j == 3));
      end
      if (j == 1) begin
        checks++;
        if (pixel_addr !== '0) begin failures++; $display("FAIL en_restart_addr0: got %0d required 0", pixel_addr); end
      end
      if (j == 2) begin
        checks++;
        if (rgb !== 12'hABC) begin failures++; $display("FAIL en_restart_rgb: got %h required ABC", rgb); end
      end
      if (j == 4) begin
        checks++;
        if (pixel_addr !== 19'd1) begin failures++; $display("FAIL en_restart_addr1: got %0d required 1", pixel_addr); end
      end
    end
    $display("test_en_drop done: checks=%0d failures=%0d", checks, failures);
  endtask

  // Restarts the scan with test_mode=1; j counts clk after en rises
  task automatic test_pattern();
    int          js  [6];
    int          hs  [6];
    logic [11:0] exps[6];
    js = '{3, 319, 323, 2243, 2559, 2563};
    hs = '{0, 79, 80, 560, 639, 640};
`ifdef VGA_TEST_PATTERN_EN
    exps = '{12'h000, 12'h000, 12'h00F, 12'hFFF, 12'hFFF, 12'h000};
`else
    exps = '{12'h123, 12'h123, 12'h123, 12'h123, 12'h123, 12'h000};
`endif
    en         = 1'b0;
    test_mode  = 1'b1;
    pixel_data = 16'hF123;
    @(negedge clk);
    @(negedge clk);
    en = 1'b1;
    for (int j = 1; j <= 2563; j++) begin
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
        if (j == js[i]) begin
          checks++;
          if (rgb !== exps[i]) begin
            failures++;
            $display("FAIL pattern_px%0d: got %h required %h", hs[i], rgb, exps[i]);
          end
        end
      end
    end
    $display("test_pattern done: checks=%0d failures=%0d", checks, failures);
  endtask

  // Continues the scan started by test_pattern; reset lands between edges
  task automatic test_async_reset();
    logic [11:0] exp_rgb;
`ifdef VGA_TEST_PATTERN_EN
    exp_rgb = 12'hFFF;
`else
    exp_rgb = 12'h123;
`endif
    for (int j = 2564; j <= 5603; j++) @(negedge clk);
    checks += 2;
    if (rgb !== exp_rgb) begin failures++; $display("FAIL areset_pre_rgb: got %h required %h", rgb, exp_rgb); end
    if (pixel_addr !== 19'd1240) begin failures++; $display("FAIL areset_pre_addr: got %0d required 1240", pixel_addr); end
    #2;
    reset = 1'b1;
    #1;
    checks += 4;
    if (rgb !== 12'h000) begin failures++; $display("FAIL areset_rgb: got %h required 000", rgb); end
    if (pixel_addr !== '0) begin failures++; $display("FAIL areset_addr: got %0d required 0", pixel_addr); end
    if (h_sync !== 1'b1) begin failures++; $display("FAIL areset_h_sync: got %b required 1", h_sync); end
    if (v_sync !== 1'b1) begin failures++; $display("FAIL areset_v_sync: got %b required 1", v_sync); end
    for (int i = 0; i < 3; i++) @(negedge clk);
    checks++;
    if (rgb !== 12'h000 || pixel_addr !== '0) begin
      failures++;
      $display("FAIL areset_hold: got rgb=%h addr=%0d required 000/0", rgb, pixel_addr);
    end
    reset     = 1'b0;
    test_mode = 1'b0;
    $display("test_async_reset done: checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    reset      = 1'b1;
    en         = 1'b0;
    test_mode  = 1'b0;
    pixel_data = 16'h0000;
    @(negedge clk);
    test_reset();
    test_first_pixel();
    test_line();
    test_frame();
    test_en_drop();
    test_pattern();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
